// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder and the display controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_ctrl_pkg;

    localparam int DEF_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// Optional port sub exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) ();

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell; purely combinational, zero latency.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder on one FA cell, LSB first; done pulses N+1 cycles after an accepted start.
// start is only accepted in IDLE or DONE and ignored while busy; SERIAL_ADD_SUB_EN adds a subtract mode.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic               clk,
    input  logic               reset,
    serial_add_ctrl_if.slave   bus
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             state;
    state_t             state_nxt;
    logic [N-1:0]       a_sh;
    logic [N-1:0]       b_sh;
    logic [N-1:0]       sum_sh;
    logic [N-1:0]       sum_nxt;
    logic [N-1:0]       sum_q;
    logic               carry;
    logic               cout_q;
    logic [CNT_W-1:0]   cnt;
    logic               fa_s;
    logic               fa_co;
    logic               accept;
    logic               last;
    logic [N-1:0]       b_ld;
    logic               c_ld;
    logic               busy_o;
    logic               done_o;

`ifdef SERIAL_ADD_SUB_EN
    // a - b computed as a + ~b + 1; cout then means "no borrow"
    assign b_ld = bus.sub ? ~bus.b : bus.b;
    assign c_ld = bus.sub ? 1'b1   : bus.cin;
`else
    assign b_ld = bus.b;
    assign c_ld = bus.cin;
`endif

    assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last   = (cnt == CNT_W'(N - 1));

    serial_add_ctrl_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        sum_nxt        = sum_sh >> 1;
        sum_nxt[N-1]   = fa_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: state_nxt = bus.start ? ST_RUN : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state)
            ST_RUN:  busy_o = 1'b1;
            ST_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    // Visible result only changes on the edge entering DONE, never mid-run
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= b_ld;
            carry  <= c_ld;
            sum_sh <= '0;
            cnt    <= '0;
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt;
            carry  <= fa_co;
            cnt    <= cnt + CNT_W'(1);
            if (last) begin
                sum_q  <= sum_nxt;
                cout_q <= fa_co;
            end
        end
    end

    assign bus.busy = busy_o;
    assign bus.done = done_o;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule
